// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg: shared encodings for the instruction-memory arbiter.
// Holds the BOOT/RUN state type, the read-owner type and the byte-to-word
// shift used to derive the memory word index from a byte address.
package imem_arbiter_pkg;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } arb_state_e;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_LOAD  = 2'd2
   } arb_owner_e;

   // Byte address bit where the word index starts (32-bit words).
   localparam int unsigned WORD_LSB = 2;

endpackage

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: bundles the fetch port, loader port, status outputs and
// memory command bus of the arbiter. "slave" is the arbiter side, "master"
// is the environment (CPU, loader and memory) side.
interface imem_arbiter_if #(
   parameter int DEPTH_LOG2 = 6
) ();

   logic                  fetch_req;
   logic [31:0]           fetch_addr;
   logic                  fetch_gnt;
   logic                  fetch_rvalid;
   logic [31:0]           fetch_rdata;

   logic                  load_req;
   logic                  load_we;
   logic [31:0]           load_addr;
   logic [31:0]           load_wdata;
   logic                  load_gnt;
   logic                  load_rvalid;
   logic [31:0]           load_rdata;
   logic                  load_done;

   logic                  mem_en;
   logic                  mem_we;
   logic [DEPTH_LOG2-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;

   logic                  stall;
   logic                  booted;
   logic                  align_err;

   modport slave (
      input  fetch_req, fetch_addr,
      input  load_req, load_we, load_addr, load_wdata, load_done,
      input  mem_rdata,
      output fetch_gnt, fetch_rvalid, fetch_rdata,
      output load_gnt, load_rvalid, load_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output stall, booted, align_err
   );

   modport master (
      output fetch_req, fetch_addr,
      output load_req, load_we, load_addr, load_wdata, load_done,
      output mem_rdata,
      input  fetch_gnt, fetch_rvalid, fetch_rdata,
      input  load_gnt, load_rvalid, load_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  stall, booted, align_err
   );

endinterface

// File: rtl/imem_arb_starve.sv
// imem_arb_starve: counts consecutive RUN cycles in which fetch asked but was
// denied. The count saturates at STARVE_MAX; force_fetch is high while the
// count sits at that ceiling so the arbiter lets fetch win over load.
module imem_arb_starve #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic fetch_req,
   input  logic fetch_gnt,
   output logic force_fetch
);

   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

   logic [CW-1:0] cnt_d, cnt_q;

   // Next count: clear when fetch is served or idle, count denials in RUN.
   always_comb begin
      cnt_d = cnt_q;
      if (!fetch_req || fetch_gnt) begin
         cnt_d = '0;
      end else if (run && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign force_fetch = (cnt_q == CNT_MAX);

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port instruction memory between the CPU
// fetch port and a loader/debug port. In BOOT only the loader is served; a
// load_done pulse moves to RUN, where load has priority unless fetch has been
// starved for STARVE_MAX cycles. Read data returns one cycle after the grant.
// Optional build macro IMEM_ARB_ALIGN_CHK_EN: misaligned granted requests are
// acknowledged but not issued to memory, and raise a sticky align_err.
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int DEPTH_LOG2 = 6,
   parameter int STARVE_MAX = 4
) (
   input  logic           clk,
   input  logic           reset,
   imem_arbiter_if.slave  bus
);

   arb_state_e             state_d, state_q;
   arb_owner_e             rd_owner_d, rd_owner_q;
   logic                   force_fetch_s;
   logic                   fetch_gnt_s;
   logic                   load_gnt_s;
   logic [31:0]            gnt_addr_s;
   logic                   misalign_s;
   logic                   mem_en_s;
   logic                   mem_we_s;
   logic [31:0]            fetch_rdata_d, fetch_rdata_q;
   logic [31:0]            load_rdata_d, load_rdata_q;
   logic                   fetch_rvalid_s;
   logic                   load_rvalid_s;
   logic                   unused_addr_s;

   imem_arb_starve #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk         (clk),
      .reset       (reset),
      .run         (state_q == ST_RUN),
      .fetch_req   (bus.fetch_req),
      .fetch_gnt   (fetch_gnt_s),
      .force_fetch (force_fetch_s)
   );

   // Grant decision: loader only in BOOT; in RUN load wins unless fetch is starved.
   always_comb begin
      fetch_gnt_s = 1'b0;
      load_gnt_s  = 1'b0;
      if (!reset) begin
         fetch_gnt_s = 1'b0;
         load_gnt_s  = 1'b0;
      end else begin
         case (state_q)
            ST_BOOT: begin
               load_gnt_s = bus.load_req;
            end
            ST_RUN: begin
               if (bus.fetch_req && (!bus.load_req || force_fetch_s)) begin
                  fetch_gnt_s = 1'b1;
               end else begin
                  load_gnt_s = bus.load_req;
               end
            end
            default: begin
               fetch_gnt_s = 1'b0;
               load_gnt_s  = 1'b0;
            end
         endcase
      end
   end

   // Address of whichever port holds the grant this cycle.
   always_comb begin
      gnt_addr_s = 32'd0;
      if (fetch_gnt_s) begin
         gnt_addr_s = bus.fetch_addr;
      end else if (load_gnt_s) begin
         gnt_addr_s = bus.load_addr;
      end else begin
         gnt_addr_s = 32'd0;
      end
   end

`ifdef IMEM_ARB_ALIGN_CHK_EN
   logic align_err_d, align_err_q;

   assign misalign_s = (fetch_gnt_s || load_gnt_s) && (gnt_addr_s[1:0] != 2'b00);

   // Sticky flag: any misaligned granted request sets it until reset.
   always_comb begin
      align_err_d = align_err_q | misalign_s;
   end

   // Alignment error register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         align_err_q <= 1'b0;
      end else begin
         align_err_q <= align_err_d;
      end
   end

   assign bus.align_err = align_err_q;
`else
   assign misalign_s    = 1'b0;
   assign bus.align_err = 1'b0;
`endif

   assign mem_en_s = (fetch_gnt_s || load_gnt_s) && !misalign_s;
   assign mem_we_s = mem_en_s && load_gnt_s && bus.load_we;

   // Bits outside the word index are ignored: the address wraps modulo depth.
   assign unused_addr_s = ^{gnt_addr_s[31:DEPTH_LOG2+WORD_LSB], gnt_addr_s[WORD_LSB-1:0]};

   // Next-state logic: BOOT leaves on load_done, RUN is only left by reset.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT: begin
            if (bus.load_done) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_BOOT;
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // Remember which port issued a memory read so its data is steered next cycle.
   always_comb begin
      rd_owner_d = OWN_NONE;
      if (mem_en_s && !mem_we_s) begin
         if (fetch_gnt_s) begin
            rd_owner_d = OWN_FETCH;
         end else begin
            rd_owner_d = OWN_LOAD;
         end
      end else begin
         rd_owner_d = OWN_NONE;
      end
   end

   assign fetch_rvalid_s = reset && (rd_owner_q == OWN_FETCH);
   assign load_rvalid_s  = reset && (rd_owner_q == OWN_LOAD);

   // Read-data hold registers: capture returned data, otherwise keep last value.
   always_comb begin
      fetch_rdata_d = fetch_rdata_q;
      load_rdata_d  = load_rdata_q;
      if (fetch_rvalid_s) begin
         fetch_rdata_d = bus.mem_rdata;
      end else begin
         fetch_rdata_d = fetch_rdata_q;
      end
      if (load_rvalid_s) begin
         load_rdata_d = bus.mem_rdata;
      end else begin
         load_rdata_d = load_rdata_q;
      end
   end

   // State, read-owner and held read-data registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_BOOT;
         rd_owner_q    <= OWN_NONE;
         fetch_rdata_q <= 32'd0;
         load_rdata_q  <= 32'd0;
      end else begin
         state_q       <= state_d;
         rd_owner_q    <= rd_owner_d;
         fetch_rdata_q <= fetch_rdata_d;
         load_rdata_q  <= load_rdata_d;
      end
   end

   assign bus.fetch_gnt    = fetch_gnt_s;
   assign bus.load_gnt     = load_gnt_s;
   assign bus.fetch_rvalid = fetch_rvalid_s;
   assign bus.load_rvalid  = load_rvalid_s;
   assign bus.fetch_rdata  = fetch_rvalid_s ? bus.mem_rdata : fetch_rdata_q;
   assign bus.load_rdata   = load_rvalid_s  ? bus.mem_rdata : load_rdata_q;
   assign bus.mem_en       = mem_en_s;
   assign bus.mem_we       = mem_we_s;
   assign bus.mem_addr     = gnt_addr_s[DEPTH_LOG2+WORD_LSB-1:WORD_LSB];
   assign bus.mem_wdata    = load_gnt_s ? bus.load_wdata : 32'd0;
   assign bus.stall        = bus.fetch_req && !fetch_gnt_s;
   assign bus.booted       = (state_q == ST_RUN);

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter DEPTH_LOG2, default 6, word-address width of the shared instruction memory (64 words).
REQ-002 Parameter STARVE_MAX, default 4, consecutive fetch-denied cycles before fetch is forced to win.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 fetch_req  input  1 / fetch_addr  input  32  CPU instruction read request, byte address.
REQ-006 fetch_gnt  output  1 / fetch_rvalid  output  1 / fetch_rdata  output  32  grant, read-data valid, instruction word.
REQ-007 load_req  input  1 / load_we  input  1 / load_addr  input  32 / load_wdata  input  32  loader/debug port, read or write.
REQ-008 load_gnt  output  1 / load_rvalid  output  1 / load_rdata  output  32  loader grant, read valid, read data.
REQ-009 load_done  input  1  one-cycle pulse: program image complete.
REQ-010 mem_en  output  1 / mem_we  output  1 / mem_addr  output  DEPTH_LOG2 / mem_wdata  output  32  memory command.
REQ-011 mem_rdata  input  32  memory read data, registered, valid one cycle after mem_en with mem_we=0.
REQ-012 stall  output  1  fetch_req high and fetch_gnt low this cycle.
REQ-013 booted  output  1  high in RUN state.
REQ-014 align_err  output  1  sticky misalignment flag (see Configuration).

Function
REQ-015 FSM states BOOT and RUN; BOOT -> RUN on the cycle after load_done=1; RUN -> BOOT only via reset.
REQ-016 BOOT: only load port granted; fetch_gnt=0 always, so stall=fetch_req.
REQ-017 RUN: at most one grant per cycle; load wins if both request, unless starve counter equals STARVE_MAX, then fetch wins.
REQ-018 Starve counter: increments each RUN cycle with fetch_req=1 and fetch_gnt=0, saturates at STARVE_MAX, clears on fetch grant or fetch_req=0.
REQ-019 Grants are combinational from current requests and state; a granted request drives mem_en=1 in the same cycle.
REQ-020 mem_addr = granted address bits [DEPTH_LOG2+1:2]; higher bits ignored (address wraps modulo depth).
REQ-021 mem_we = load_we only when load is granted; fetch never writes.
REQ-022 Read granted in cycle N -> owning port's rvalid=1 with rdata=mem_rdata in cycle N+1, for exactly one cycle; writes produce no rvalid.
REQ-023 rdata of a non-valid port holds its last value; back-to-back reads give rvalid every cycle.
REQ-024 load_done with load_req in the same cycle: load is served, transition still occurs.

Reset
REQ-025 On reset=0 at a clock edge: state=BOOT, starve counter=0, all gnt/rvalid=0, rdata=0, align_err=0, booted=0.
REQ-026 A read granted in the cycle before reset produces no rvalid after reset.
REQ-027 mem_en=0 while reset=0.

Configuration
REQ-028 Macro IMEM_ARB_ALIGN_CHK_EN defined: a granted request with addr[1:0]!=0 is acknowledged (gnt=1) but mem_en=0, no rvalid, and align_err sets until reset.
REQ-029 Macro undefined: addr[1:0] ignored, align_err tied 0, no check logic.

Structure
REQ-030 Shared package holds state encoding (BOOT, RUN), port-owner encoding (NONE, FETCH, LOAD) and the word-index derivation constant 2.
REQ-031 One sub-module imem_arb_starve (saturating starve counter and force flag); remainder flat.

Verification
REQ-032 Reset, fetch_req=1 with no load_done -> stall=1, fetch_gnt=0 indefinitely, booted=0.
REQ-033 BOOT, load write addr 0x8 data 0xDEADBEEF -> mem_en=1, mem_we=1, mem_addr=2; load_done -> booted=1 next cycle.
REQ-034 RUN, fetch read 0x8 -> fetch_gnt same cycle, fetch_rvalid=1 with fetch_rdata=0xDEADBEEF one cycle later.
REQ-035 RUN, both requesting continuously, STARVE_MAX=4 -> four load grants then one fetch grant, repeating.
REQ-036 Read granted, reset=0 next cycle -> no rvalid, all outputs at reset values.
REQ-037 With IMEM_ARB_ALIGN_CHK_EN, fetch addr 0x6 -> fetch_gnt=1, mem_en=0, no rvalid, align_err=1 sticky.
